// File: rtl/seq_match_if.sv
// Bundle of configuration, serial-input and status signals between firmware
// logic and the pattern-match run controller.
interface seq_match_if #(
    parameter int PW = 8,
    parameter int CW = 16,
    parameter int LW = $clog2(PW) + 1
);
    logic          start;
    logic [PW-1:0] pattern;
    logic [LW-1:0] pat_len;
    logic [CW-1:0] frame_len;
    logic          in_valid;
    logic          in;
    logic          busy;
    logic          match;
    logic [CW-1:0] match_count;
    logic          done;
    logic          err_cfg;

    modport master (
        output start, pattern, pat_len, frame_len, in_valid, in,
        input  busy, match, match_count, done, err_cfg
    );

    modport slave (
        input  start, pattern, pat_len, frame_len, in_valid, in,
        output busy, match, match_count, done, err_cfg
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run controller for serial pattern detection: one frame per accepted start,
// overlapping matches, match pulse/count and a single-cycle done pulse.
module seq_match_ctrl #(
    parameter  int PW = 8,
    parameter  int CW = 16,
    localparam int LW = $clog2(PW) + 1
) (
    input  logic         clk,
    input  logic         rstn,
    seq_match_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q;
    logic [PW-2:0] shreg_q;
    logic [CW-1:0] bitcnt_q;
    logic [CW-1:0] match_count_q;
    logic [PW-1:0] pat_q;
    logic [LW-1:0] pat_len_q;
    logic [CW-1:0] frame_len_q;
    logic          busy_q;
    logic          match_q;
    logic          done_q;
    logic          err_cfg_q;

    logic [PW-1:0] shreg_d;
    logic [PW-1:0] mask_d;
    logic [CW-1:0] bitcnt_d;
    logic          hit_d;
    logic          last_d;
    logic          cfg_ok_d;

    // Only PW-1 history bits are stored; the newest bit completes the window.
    assign shreg_d  = {shreg_q, bus.in};
    assign bitcnt_d = bitcnt_q + CW'(1);

    // NOTE: every bit gets a default before the loop, so no latch is inferred.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < PW; i++) begin
            mask_d[i] = (i < int'(pat_len_q));
        end
    end

    assign hit_d    = (bitcnt_d >= CW'(pat_len_q)) &&
                      (((shreg_d ^ pat_q) & mask_d) == '0);
    assign last_d   = (bitcnt_d == frame_len_q);
    assign cfg_ok_d = (bus.pat_len != '0) && (bus.pat_len <= LW'(PW)) &&
                      (bus.frame_len != '0);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every read in this block sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            match_count_q <= '0;
            pat_q         <= '0;
            pat_len_q     <= '0;
            frame_len_q   <= '0;
            busy_q        <= 1'b0;
            match_q       <= 1'b0;
            done_q        <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            err_cfg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok_d) begin
                            pat_q         <= bus.pattern;
                            pat_len_q     <= bus.pat_len;
                            frame_len_q   <= bus.frame_len;
                            shreg_q       <= '0;
                            bitcnt_q      <= '0;
                            match_count_q <= '0;
                            busy_q        <= 1'b1;
                            state_q       <= RUN;
                        end else begin
                            err_cfg_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        shreg_q  <= shreg_d[PW-2:0];
                        bitcnt_q <= bitcnt_d;
                        if (hit_d) begin
                            match_q       <= 1'b1;
                            match_count_q <= match_count_q + CW'(1);
                        end
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.match       = match_q;
    assign bus.match_count = match_count_q;
    assign bus.done        = done_q;
    assign bus.err_cfg     = err_cfg_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: a queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_seq_match_ctrl;

    localparam int PW = 8;
    localparam int CW = 16;
    localparam int LW = $clog2(PW) + 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    seq_match_if #(.PW(PW), .CW(CW)) bus();

    seq_match_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is a list of accepted bits; a match is the
    // tail of that list spelling the pattern, MSB first.
    bit          m_live = 0;
    bit          m_in_frame = 0;
    bit          m_done_cycle = 0;
    logic [PW-1:0] m_pat;
    int          m_len;
    int          m_flen;
    bit          hist[$];
    logic        exp_busy = 0, exp_match = 0, exp_done = 0, exp_err = 0;
    int          exp_count = 0;

    function automatic bit tail_matches();
        for (int k = 0; k < m_len; k++) begin
            if (hist[hist.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            exp_match = 0;
            exp_done  = 0;
            exp_err   = 0;
            if (rstn === 1'b1) begin
                m_live = 1;
                m_in_frame = 0;
                m_done_cycle = 0;
                exp_busy = 0;
                exp_count = 0;
                hist.delete();
            end else if (m_done_cycle) begin
                m_done_cycle = 0;
            end else if (!m_in_frame) begin
                if (bus.start) begin
                    if (bus.pat_len >= 1 && bus.pat_len <= PW && bus.frame_len >= 1) begin
                        m_pat  = bus.pattern;
                        m_len  = int'(bus.pat_len);
                        m_flen = int'(bus.frame_len);
                        hist.delete();
                        exp_count  = 0;
                        m_in_frame = 1;
                        exp_busy   = 1;
                    end else begin
                        exp_err = 1;
                    end
                end
            end else if (bus.in_valid) begin
                hist.push_back(bus.in);
                if (hist.size() >= m_len && tail_matches()) begin
                    exp_match = 1;
                    exp_count++;
                end
                if (hist.size() == m_flen) begin
                    m_in_frame   = 0;
                    m_done_cycle = 1;
                    exp_busy     = 0;
                    exp_done     = 1;
                end
            end
        end
    end

    // Per-cycle compare plus event counters used by the directed checks.
    int cnt_match, cnt_busy, cnt_done, cnt_err, done_with_match;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("cyc_busy",  bus.busy,        exp_busy);
                check("cyc_match", bus.match,       exp_match);
                check("cyc_done",  bus.done,        exp_done);
                check("cyc_err",   bus.err_cfg,     exp_err);
                check("cyc_count", bus.match_count, exp_count);
                cnt_match += int'(bus.match);
                cnt_busy  += int'(bus.busy);
                cnt_done  += int'(bus.done);
                cnt_err   += int'(bus.err_cfg);
                if (bus.done === 1'b1) done_with_match = int'(bus.match);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cnt_match = 0; cnt_busy = 0; cnt_done = 0; cnt_err = 0; done_with_match = 0;
    endtask

    task automatic start_frame(input logic [PW-1:0] pat, input logic [LW-1:0] len,
                               input logic [CW-1:0] flen);
        bus.start = 1'b1; bus.pattern = pat; bus.pat_len = len; bus.frame_len = flen;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.in_valid = 1'b1; bus.in = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_gap();
        bus.in_valid = 1'b0; bus.in = 1'($urandom);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [6:0]  t1_bits = 7'b0110110;
    logic [6:0]  t1_hits = 7'b0001001;
    logic [15:0] t6_bits = 16'hA5A5;

    initial begin
        rstn = 1'b1;
        bus.start = 0; bus.in_valid = 0; bus.in = 0;
        bus.pattern = '0; bus.pat_len = '0; bus.frame_len = '0;
        idle(2);
        rstn = 1'b0;
        check("rst_busy",  bus.busy,        0);
        check("rst_match", bus.match,       0);
        check("rst_done",  bus.done,        0);
        check("rst_err",   bus.err_cfg,     0);
        check("rst_count", bus.match_count, 0);

        // 1: overlapping 0110 in 0110110
        clear_mon();
        start_frame(8'b0110, 4, 7);
        for (int i = 6; i >= 0; i--) begin
            send_bit(t1_bits[i]);
            check($sformatf("t1_match_bit%0d", 7 - i), bus.match, t1_hits[i]);
        end
        idle(3);
        check("t1_matches",    cnt_match,       2);
        check("t1_busy_cyc",   cnt_busy,        7);
        check("t1_done",       cnt_done,        1);
        check("t1_done_match", done_with_match, 1);
        check("t1_count",      bus.match_count, 2);

        // 2: same frame with gaps after every bit
        clear_mon();
        start_frame(8'b0110, 4, 7);
        for (int i = 6; i >= 0; i--) begin
            send_bit(t1_bits[i]);
            send_gap();
        end
        idle(2);
        check("t2_matches",    cnt_match,       2);
        check("t2_busy_cyc",   cnt_busy,        13);
        check("t2_done",       cnt_done,        1);
        check("t2_done_match", done_with_match, 1);
        check("t2_count",      bus.match_count, 2);

        // 3: illegal configurations rejected, count retained
        clear_mon();
        start_frame(8'b0110, 0, 7); tick();
        start_frame(8'b0110, 9, 7); tick();
        start_frame(8'b0110, 4, 0); tick();
        check("t3_errs",  cnt_err,         3);
        check("t3_busy",  cnt_busy,        0);
        check("t3_count", bus.match_count, 2);

        // 4: start while busy is ignored
        clear_mon();
        start_frame(8'b0110, 4, 7);
        send_bit(0); send_bit(1); send_bit(1);
        bus.start = 1'b1; bus.pattern = 8'hFF; bus.pat_len = 2; bus.frame_len = 3;
        send_bit(0);
        bus.start = 1'b0;
        send_bit(1); send_bit(1); send_bit(0);
        idle(2);
        check("t4_count",    bus.match_count, 2);
        check("t4_done",     cnt_done,        1);
        check("t4_busy_cyc", cnt_busy,        7);

        // 5: reset mid-run
        clear_mon();
        start_frame(8'b0110, 4, 7);
        send_bit(0); send_bit(1); send_bit(1);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        check("t5_busy",  bus.busy,        0);
        check("t5_count", bus.match_count, 0);
        idle(3);
        check("t5_done", cnt_done, 0);

        // 6a: full-width pattern
        clear_mon();
        start_frame(8'hA5, 8, 16);
        for (int i = 15; i >= 0; i--) send_bit(t6_bits[i]);
        idle(2);
        check("t6a_count", bus.match_count, 2);
        check("t6a_done",  cnt_done,        1);

        // 6b: single-bit pattern, every bit matches
        clear_mon();
        start_frame(8'h01, 1, 5);
        for (int i = 0; i < 5; i++) begin
            send_bit(1);
            check($sformatf("t6b_match_bit%0d", i + 1), bus.match, 1);
        end
        idle(2);
        check("t6b_matches", cnt_match,       5);
        check("t6b_count",   bus.match_count, 5);

        // Randomized frames, stray starts, gaps and occasional resets
        for (int f = 0; f < 60; f++) begin
            int guard;
            start_frame(8'($urandom), LW'($urandom_range(0, 9)), CW'($urandom_range(0, 30)));
            guard = 0;
            while (m_in_frame && guard < 400) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in        = 1'($urandom);
                bus.start     = ($urandom_range(0, 15) == 0);
                bus.pattern   = 8'($urandom);
                bus.pat_len   = LW'($urandom_range(0, 9));
                bus.frame_len = CW'($urandom_range(0, 30));
                rstn          = ($urandom_range(0, 199) == 0);
                tick();
                guard++;
            end
            rstn = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
            if (guard >= 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_frame_timeout: frame %0d still open after %0d cycles", f, guard);
            end
            bus.in_valid = 1'($urandom);
            bus.in = 1'($urandom);
            idle(2);
            bus.in_valid = 1'b0;
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
